branch_redirect_ctrl: RTL and testbench

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

---
 rtl/branch_redirect_ctrl_pkg.sv | 25 ++
 rtl/branch_redirect_ctrl.sv | 110 +++++++++++
 tb/tb_branch_redirect_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch/exception redirect controller:
// ROB index width, epoch width, FSM state encoding and small arithmetic helpers.
package branch_redirect_ctrl_pkg;

    localparam int DEF_ROB_W = 6;
    localparam int EPOCH_W   = 2;
    localparam int PC_W      = 32;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        REDIR = 2'd2
    } redir_state_e;

    // The epoch is a small wrapping tag, so 3 rolls over to 0.
    function automatic logic [EPOCH_W-1:0] nextEpoch(input logic [EPOCH_W-1:0] epoch);
        return epoch + {{(EPOCH_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] count);
        return (count == {CNT_W{1'b1}}) ? count : count + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl.sv
// Redirect controller: arbitrates BRU mispredicts and commit-time traps, bumps the
// speculation epoch, issues a one-cycle backend flush, then steers fetch to the new PC.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ROB_W = DEF_ROB_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bru_redirect_valid,
    input  logic [PC_W-1:0]     bru_redirect_pc,
    input  logic [EPOCH_W-1:0]  bru_epoch,
    input  logic [ROB_W-1:0]    bru_rob_idx,
    input  logic                exc_redirect_valid,
    input  logic [PC_W-1:0]     exc_redirect_pc,
    output logic [EPOCH_W-1:0]  cur_epoch,
    output logic                flush_valid,
    output logic                flush_all,
    output logic [ROB_W-1:0]    flush_rob_idx,
    output logic                fe_redirect_valid,
    output logic [PC_W-1:0]     fe_redirect_pc,
    input  logic                fe_redirect_ready,
    output logic                fe_stall,
    output logic [CNT_W-1:0]    redirect_cnt
);

    redir_state_e         r_state;
    logic [EPOCH_W-1:0]   r_epoch;
    logic [PC_W-1:0]      r_pc;
    logic [ROB_W-1:0]     r_rob_idx;
    logic                 r_flush_valid;
    logic                 r_flush_all;
    logic                 r_fe_valid;
    logic                 r_stall;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_take_exc;
    logic                 w_take_bru;
    logic                 w_accept;

    // An exception wins in every state; a BRU redirect only counts in IDLE with a
    // matching epoch, since anything arriving during recovery is already stale.
    assign w_take_exc = exc_redirect_valid;
    assign w_take_bru = (r_state == IDLE) && bru_redirect_valid
                        && (bru_epoch == r_epoch) && !exc_redirect_valid;
    assign w_accept   = w_take_exc || w_take_bru;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_epoch       <= '0;
            r_pc          <= '0;
            r_rob_idx     <= '0;
            r_flush_valid <= 1'b0;
            r_flush_all   <= 1'b0;
            r_fe_valid    <= 1'b0;
            r_stall       <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_flush_valid <= 1'b0;
            r_flush_all   <= 1'b0;
            if (w_accept) begin
                // New or preempting redirect: restart recovery from FLUSH.
                r_state       <= FLUSH;
                r_epoch       <= nextEpoch(r_epoch);
                r_pc          <= w_take_exc ? exc_redirect_pc : bru_redirect_pc;
                r_rob_idx     <= w_take_exc ? '0 : bru_rob_idx;
                r_flush_valid <= 1'b1;
                r_flush_all   <= w_take_exc;
                r_fe_valid    <= 1'b0;
                r_stall       <= 1'b1;
                r_cnt         <= satInc(r_cnt);
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_fe_valid <= 1'b0;
                        r_stall    <= 1'b0;
                    end
                    FLUSH: begin
                        r_state    <= REDIR;
                        r_fe_valid <= 1'b1;
                        r_stall    <= 1'b1;
                    end
                    REDIR: begin
                        if (fe_redirect_ready) begin
                            r_state    <= IDLE;
                            r_fe_valid <= 1'b0;
                            r_stall    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_fe_valid <= 1'b0;
                        r_stall    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cur_epoch         = r_epoch;
    assign flush_valid       = r_flush_valid;
    assign flush_all         = r_flush_all;
    assign flush_rob_idx     = r_rob_idx;
    assign fe_redirect_valid = r_fe_valid;
    assign fe_redirect_pc    = r_pc;
    assign fe_stall          = r_stall;
    assign redirect_cnt      = r_cnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_branch_redirect_ctrl;
    import branch_redirect_ctrl_pkg::*;

    localparam int RW = DEF_ROB_W;

    logic             clk;
    logic             rst_n;
    logic             bruValid;
    logic [31:0]      bruPc;
    logic [1:0]       bruEpoch;
    logic [RW-1:0]    bruIdx;
    logic             excValid;
    logic [31:0]      excPc;
    logic [1:0]       curEpoch;
    logic             flushValid;
    logic             flushAll;
    logic [RW-1:0]    flushIdx;
    logic             feValid;
    logic [31:0]      fePc;
    logic             feReady;
    logic             feStall;
    logic [15:0]      redirCnt;

    int vecCount = 0;
    int errCount = 0;

    branch_redirect_ctrl #(.ROB_W(RW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bru_redirect_valid (bruValid),
        .bru_redirect_pc    (bruPc),
        .bru_epoch          (bruEpoch),
        .bru_rob_idx        (bruIdx),
        .exc_redirect_valid (excValid),
        .exc_redirect_pc    (excPc),
        .cur_epoch          (curEpoch),
        .flush_valid        (flushValid),
        .flush_all          (flushAll),
        .flush_rob_idx      (flushIdx),
        .fe_redirect_valid  (feValid),
        .fe_redirect_pc     (fePc),
        .fe_redirect_ready  (feReady),
        .fe_stall           (feStall),
        .redirect_cnt       (redirCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic bv, input logic [31:0] bpc, input logic [1:0] bep,
                                 input logic [RW-1:0] bidx, input logic ev, input logic [31:0] epc);
        bruValid = bv;
        bruPc    = bpc;
        bruEpoch = bep;
        bruIdx   = bidx;
        excValid = ev;
        excPc    = epc;
    endtask

    task automatic clearStimulus();
        applyStimulus(1'b0, 32'h0, 2'd0, '0, 1'b0, 32'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Snapshot of the main control outputs against expected values.
    task automatic checkCtl(input string tag, input logic fv, input logic fa, input logic fev,
                            input logic st, input logic [1:0] ep, input logic [15:0] cnt);
        checkOutput({tag, ".flush_valid"}, 32'(flushValid), 32'(fv));
        checkOutput({tag, ".flush_all"},   32'(flushAll),   32'(fa));
        checkOutput({tag, ".fe_valid"},    32'(feValid),    32'(fev));
        checkOutput({tag, ".fe_stall"},    32'(feStall),    32'(st));
        checkOutput({tag, ".cur_epoch"},   32'(curEpoch),   32'(ep));
        checkOutput({tag, ".redir_cnt"},   32'(redirCnt),   32'(cnt));
    endtask

    initial begin
        rst_n   = 1'b0;
        feReady = 1'b1;
        clearStimulus();
        tick();
        tick();
        checkCtl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        checkOutput("reset.fe_pc", fePc, 32'h0);
        checkOutput("reset.flush_idx", 32'(flushIdx), 32'h0);
        rst_n = 1'b1;
        tick();

        // Matching-epoch BRU redirect: flush at T+1, fetch redirect at T+2.
        applyStimulus(1'b1, 32'h1000, 2'd0, RW'(5), 1'b0, 32'h0);
        tick();
        clearStimulus();
        checkCtl("bru.t1", 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'd1);
        checkOutput("bru.t1.flush_idx", 32'(flushIdx), 32'd5);
        tick();
        checkCtl("bru.t2", 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 16'd1);
        checkOutput("bru.t2.fe_pc", fePc, 32'h1000);
        tick();
        checkCtl("bru.t3", 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'd1);

        // BRU and exception together: exception wins, epoch advances once.
        applyStimulus(1'b1, 32'h3000, 2'd1, RW'(7), 1'b1, 32'h80);
        tick();
        clearStimulus();
        checkCtl("both.t1", 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 16'd2);
        tick();
        checkCtl("both.t2", 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 16'd2);
        checkOutput("both.t2.fe_pc", fePc, 32'h80);
        tick();

        // Bring epoch to 3 with another accepted BRU redirect.
        applyStimulus(1'b1, 32'h4000, 2'd2, RW'(9), 1'b0, 32'h0);
        tick();
        clearStimulus();
        checkCtl("ep3.t1", 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 16'd3);
        checkOutput("ep3.t1.flush_idx", 32'(flushIdx), 32'd9);
        tick();
        tick();
        checkCtl("ep3.idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 16'd3);

        // Stale epoch 2 while current is 3: silently dropped.
        applyStimulus(1'b1, 32'h5555, 2'd2, RW'(1), 1'b0, 32'h0);
        tick();
        clearStimulus();
        checkCtl("stale", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 16'd3);
        tick();
        checkCtl("stale.t2", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 16'd3);

        // Fourth accepted redirect wraps the epoch 3 -> 0.
        applyStimulus(1'b1, 32'h6000, 2'd3, RW'(2), 1'b0, 32'h0);
        tick();
        clearStimulus();
        checkCtl("wrap", 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'd4);
        tick();
        tick();

        // Fetch back-pressure for 3 cycles, BRU ignored in REDIR, then exception preempts.
        feReady = 1'b0;
        applyStimulus(1'b1, 32'h5000, 2'd0, RW'(3), 1'b0, 32'h0);
        tick();
        clearStimulus();
        checkCtl("bp.flush", 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'd5);
        tick();
        checkCtl("bp.redir1", 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 16'd5);
        checkOutput("bp.redir1.fe_pc", fePc, 32'h5000);
        applyStimulus(1'b1, 32'h7777, 2'd1, RW'(4), 1'b0, 32'h0);
        tick();
        clearStimulus();
        checkCtl("bp.redir2", 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 16'd5);
        checkOutput("bp.redir2.fe_pc", fePc, 32'h5000);
        tick();
        checkCtl("bp.redir3", 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 16'd5);
        applyStimulus(1'b0, 32'h0, 2'd0, '0, 1'b1, 32'h200);
        tick();
        clearStimulus();
        checkCtl("pre.flush", 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 16'd6);
        tick();
        checkCtl("pre.redir", 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 16'd6);
        checkOutput("pre.fe_pc", fePc, 32'h200);

        // Async reset mid-REDIR clears everything without a clock edge.
        rst_n = 1'b0;
        #1;
        checkCtl("arst", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        checkOutput("arst.fe_pc", fePc, 32'h0);
        tick();
        rst_n   = 1'b1;
        feReady = 1'b1;
        tick();

        // Back in service after reset: epoch 0 accepted again.
        applyStimulus(1'b1, 32'h9000, 2'd0, RW'(11), 1'b0, 32'h0);
        tick();
        clearStimulus();
        checkCtl("post", 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'd1);
        checkOutput("post.flush_idx", 32'(flushIdx), 32'd11);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
